// File: rtl/motion_pkg.sv
// ============================================================================
// motion_pkg
// ----------------------------------------------------------------------------
// Shared constants and types for the motion detector front end.
//   H_RES_DEF / V_RES_DEF : default active frame geometry (320 x 240)
//   PIX_W_DEF             : default grayscale pixel width
//   FRAME_PIXELS          : pixels per frame at the default geometry
//   CNT_W_DEF             : width able to hold 0..FRAME_PIXELS inclusive
//   diff_state_e          : frame sequencing states of frame_diff_stats
// ============================================================================
package motion_pkg;

    localparam int H_RES_DEF    = 320;
    localparam int V_RES_DEF    = 240;
    localparam int PIX_W_DEF    = 4;
    localparam int FRAME_PIXELS = H_RES_DEF * V_RES_DEF;
    localparam int CNT_W_DEF    = $clog2(FRAME_PIXELS + 1);

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,    // idle, waiting for the first pixel of a frame
        ACTIVE   = 2'd1,    // accepting pixels of the current frame
        FLUSH    = 2'd2     // last pixel sits in stage 1; publish the total
    } diff_state_e;

endpackage

// File: rtl/diff_threshold_pixel.sv
// ============================================================================
// diff_threshold_pixel
// ----------------------------------------------------------------------------
// Combinational per-pixel change detector: hit = |curr - prev| > threshold.
// The subtraction is done one bit wider than the pixel so the magnitude never
// wraps; the strict compare means threshold 0 flags any change and the
// maximum threshold flags nothing.
//
// Ports:
//   prev_pixel       in  [PIX_W-1:0]  pixel from the previous frame
//   curr_pixel       in  [PIX_W-1:0]  live pixel
//   noise_threshold  in  [PIX_W-1:0]  largest |diff| still treated as noise
//   hit              out 1            pixel changed by more than the threshold
// ============================================================================
module diff_threshold_pixel
    import motion_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF
) (
    input  logic [PIX_W-1:0] prev_pixel,
    input  logic [PIX_W-1:0] curr_pixel,
    input  logic [PIX_W-1:0] noise_threshold,
    output logic             hit
);

    logic [PIX_W:0] curr_ext;
    logic [PIX_W:0] prev_ext;
    logic [PIX_W:0] abs_diff;

    always_comb begin
        curr_ext = {1'b0, curr_pixel};
        prev_ext = {1'b0, prev_pixel};
        if (curr_ext >= prev_ext) begin
            abs_diff = curr_ext - prev_ext;
        end else begin
            abs_diff = prev_ext - curr_ext;
        end
        hit = (abs_diff > {1'b0, noise_threshold});
    end

endmodule

// File: rtl/frame_diff_stats.sv
// ============================================================================
// frame_diff_stats
// ----------------------------------------------------------------------------
// Counts, per frame, the pixels whose |curr - prev| exceeds noise_threshold
// and publishes the complete-frame total once per frame.
//
// Pipeline:
//   stage 1 : registered hit/valid of the accepted pixel
//   stage 2 : frame accumulator and pixel index
//   publish : FLUSH folds the final stage-1 hit into the total, which is then
//             presented on diff_pixel_cnt together with a one-cycle cnt_valid.
//             The count/strobe appear on the second rising edge after the
//             edge that sampled the last pixel of the frame.
//
// Optional build macro:
//   DIFF_ROI_EN : adds roi_x0/roi_x1/roi_y0/roi_y1; only pixels inside the
//                 inclusive window are counted. Bounds are captured at
//                 frame_start and held for the frame.
//
// Ports:
//   clk              in  1            system clock
//   reset            in  1            synchronous, active-high reset
//   frame_start      in  1            pulse marking the first pixel of a frame
//   pixel_valid      in  1            prev/curr pixels valid this cycle
//   prev_pixel       in  [PIX_W-1:0]  pixel from the previous frame
//   curr_pixel       in  [PIX_W-1:0]  live camera pixel
//   noise_threshold  in  [PIX_W-1:0]  minimum |diff| exceeded to count a hit
//   roi_x0/roi_x1    in  [clog2(H_RES)-1:0]  ROI columns (DIFF_ROI_EN only)
//   roi_y0/roi_y1    in  [clog2(V_RES)-1:0]  ROI rows    (DIFF_ROI_EN only)
//   diff_pixel_cnt   out [CNT_W-1:0]  hit count of the last complete frame
//   cnt_valid        out 1            pulse when diff_pixel_cnt updates
//   frame_short      out 1            pulse when a frame restarts early
// ============================================================================
module frame_diff_stats
    import motion_pkg::*;
#(
    parameter int H_RES = H_RES_DEF,
    parameter int V_RES = V_RES_DEF,
    parameter int PIX_W = PIX_W_DEF,
    parameter int CNT_W = $clog2(H_RES * V_RES + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     frame_start,
    input  logic                     pixel_valid,
    input  logic [PIX_W-1:0]         prev_pixel,
    input  logic [PIX_W-1:0]         curr_pixel,
    input  logic [PIX_W-1:0]         noise_threshold,
`ifdef DIFF_ROI_EN
    input  logic [$clog2(H_RES)-1:0] roi_x0,
    input  logic [$clog2(H_RES)-1:0] roi_x1,
    input  logic [$clog2(V_RES)-1:0] roi_y0,
    input  logic [$clog2(V_RES)-1:0] roi_y1,
`endif
    output logic [CNT_W-1:0]         diff_pixel_cnt,
    output logic                     cnt_valid,
    output logic                     frame_short
);

    localparam int FRAME_N = H_RES * V_RES;
    localparam int IDX_W   = (FRAME_N > 1) ? $clog2(FRAME_N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_N - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    diff_state_e      state_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [CNT_W-1:0] acc_reg;
    logic             hit_reg;
    logic             hit_valid_reg;
    logic [CNT_W-1:0] publish_sum_reg;
    logic             publish_pending_reg;
    logic [CNT_W-1:0] diff_pixel_cnt_reg;
    logic             cnt_valid_reg;
    logic             frame_short_reg;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic             pixel_hit;
    logic             pixel_eligible;
    logic             accept;
    logic             last_accept;
    logic [IDX_W-1:0] cur_idx;
    logic [IDX_W-1:0] idx_next;
    logic [CNT_W-1:0] hit_add;
    logic [CNT_W-1:0] acc_plus_hit;
    diff_state_e      start_state;

    diff_threshold_pixel #(
        .PIX_W (PIX_W)
    ) u_threshold (
        .prev_pixel      (prev_pixel),
        .curr_pixel      (curr_pixel),
        .noise_threshold (noise_threshold),
        .hit             (pixel_hit)
    );

    always_comb begin
        // frame_start always opens a frame, so its pixel is accepted in any
        // state; otherwise pixels are only taken while ACTIVE.
        accept       = pixel_valid && (frame_start || (state_reg == ACTIVE));
        cur_idx      = frame_start ? '0 : idx_reg;
        last_accept  = accept && (cur_idx == LAST_IDX);
        idx_next     = cur_idx + IDX_W'(1);
        hit_add      = CNT_W'(hit_valid_reg & hit_reg);
        acc_plus_hit = acc_reg + hit_add;
        // A one-pixel frame completes on its first accepted pixel.
        start_state  = last_accept ? FLUSH : ACTIVE;
    end

    // ------------------------------------------------------------------
    // Frame sequencing, accumulation and publish
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg           <= WAIT_SOF;
            idx_reg             <= '0;
            acc_reg             <= '0;
            hit_reg             <= 1'b0;
            hit_valid_reg       <= 1'b0;
            publish_sum_reg     <= '0;
            publish_pending_reg <= 1'b0;
            diff_pixel_cnt_reg  <= '0;
            cnt_valid_reg       <= 1'b0;
            frame_short_reg     <= 1'b0;
        end else begin
            // Stage 1: only accepted pixels can carry a hit.
            hit_valid_reg <= accept;
            hit_reg       <= accept & pixel_hit & pixel_eligible;

            // Output stage: the total captured in FLUSH leaves one edge
            // later together with its strobe.
            publish_pending_reg <= 1'b0;
            cnt_valid_reg       <= publish_pending_reg;
            frame_short_reg     <= 1'b0;
            if (publish_pending_reg) begin
                diff_pixel_cnt_reg <= publish_sum_reg;
            end

            // Pixel index advances on accepted pixels only.
            if (last_accept) begin
                idx_reg <= '0;
            end else if (accept) begin
                idx_reg <= idx_next;
            end else if (frame_start) begin
                idx_reg <= '0;
            end

            case (state_reg)
                WAIT_SOF: begin
                    acc_reg <= '0;
                    if (frame_start) begin
                        state_reg <= start_state;
                    end
                end

                ACTIVE: begin
                    if (frame_start) begin
                        // Early restart: drop the partial total, including
                        // the old pixel still sitting in stage 1.
                        frame_short_reg <= 1'b1;
                        acc_reg         <= '0;
                        state_reg       <= start_state;
                    end else begin
                        acc_reg <= acc_plus_hit;
                        if (last_accept) begin
                            state_reg <= FLUSH;
                        end
                    end
                end

                FLUSH: begin
                    // Stage 1 holds the frame's last pixel here; fold it in
                    // while the accumulator restarts for any new frame.
                    publish_sum_reg     <= acc_plus_hit;
                    publish_pending_reg <= 1'b1;
                    acc_reg             <= '0;
                    state_reg           <= frame_start ? start_state : WAIT_SOF;
                end

                default: begin
                    acc_reg   <= '0;
                    state_reg <= WAIT_SOF;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Region-of-interest gating
    // ------------------------------------------------------------------
`ifdef DIFF_ROI_EN
    localparam int X_W = $clog2(H_RES);
    localparam int Y_W = $clog2(V_RES);

    logic [X_W-1:0] x_reg;
    logic [Y_W-1:0] y_reg;
    logic [X_W-1:0] roi_x0_reg;
    logic [X_W-1:0] roi_x1_reg;
    logic [Y_W-1:0] roi_y0_reg;
    logic [Y_W-1:0] roi_y1_reg;
    logic [X_W-1:0] cur_x;
    logic [Y_W-1:0] cur_y;
    logic [X_W-1:0] win_x0;
    logic [X_W-1:0] win_x1;
    logic [Y_W-1:0] win_y0;
    logic [Y_W-1:0] win_y1;

    always_comb begin
        // Column/row tracked with wrap counters instead of dividing the
        // pixel index. On frame_start the live bounds apply to pixel 0.
        cur_x  = frame_start ? '0 : x_reg;
        cur_y  = frame_start ? '0 : y_reg;
        win_x0 = frame_start ? roi_x0 : roi_x0_reg;
        win_x1 = frame_start ? roi_x1 : roi_x1_reg;
        win_y0 = frame_start ? roi_y0 : roi_y0_reg;
        win_y1 = frame_start ? roi_y1 : roi_y1_reg;
        // Swapped bounds naturally give an empty window.
        pixel_eligible = (cur_x >= win_x0) && (cur_x <= win_x1) &&
                         (cur_y >= win_y0) && (cur_y <= win_y1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_reg      <= '0;
            y_reg      <= '0;
            roi_x0_reg <= '0;
            roi_x1_reg <= '0;
            roi_y0_reg <= '0;
            roi_y1_reg <= '0;
        end else begin
            if (frame_start) begin
                roi_x0_reg <= roi_x0;
                roi_x1_reg <= roi_x1;
                roi_y0_reg <= roi_y0;
                roi_y1_reg <= roi_y1;
            end
            if (accept) begin
                if (cur_x == X_W'(H_RES - 1)) begin
                    x_reg <= '0;
                    y_reg <= (cur_y == Y_W'(V_RES - 1)) ? '0 : cur_y + Y_W'(1);
                end else begin
                    x_reg <= cur_x + X_W'(1);
                    y_reg <= cur_y;
                end
            end else if (frame_start) begin
                x_reg <= '0;
                y_reg <= '0;
            end
        end
    end
`else
    assign pixel_eligible = 1'b1;
`endif

    assign diff_pixel_cnt = diff_pixel_cnt_reg;
    assign cnt_valid      = cnt_valid_reg;
    assign frame_short    = frame_short_reg;

endmodule

// File: tb/tb_frame_diff_stats.sv
// ============================================================================
// tb_frame_diff_stats
// ----------------------------------------------------------------------------
// Self-checking bench for frame_diff_stats on a reduced 16x8 frame. Frames
// are described as pixel arrays; a frame-level reference model counts hits
// with plain arithmetic and schedules the expected publish / frame_short
// cycles. A monitor compares outputs every cycle, 2 ns after the rising edge.
// ============================================================================
module tb_frame_diff_stats;

    localparam int H  = 16;
    localparam int V  = 8;
    localparam int N  = H * V;
    localparam int PW = 4;
    localparam int CW = $clog2(N + 1);
    localparam int D3_HITS = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          frame_start;
    logic          pixel_valid;
    logic [PW-1:0] prev_pixel;
    logic [PW-1:0] curr_pixel;
    logic [PW-1:0] noise_threshold;
    logic [CW-1:0] diff_pixel_cnt;
    logic          cnt_valid;
    logic          frame_short;

    frame_diff_stats #(
        .H_RES (H),
        .V_RES (V),
        .PIX_W (PW),
        .CNT_W (CW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .frame_start     (frame_start),
        .pixel_valid     (pixel_valid),
        .prev_pixel      (prev_pixel),
        .curr_pixel      (curr_pixel),
        .noise_threshold (noise_threshold),
        .diff_pixel_cnt  (diff_pixel_cnt),
        .cnt_valid       (cnt_valid),
        .frame_short     (frame_short)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model (frame level)
    // ------------------------------------------------------------------
    bit in_frame  = 1'b0;
    int pix_cnt   = 0;
    int hit_cnt   = 0;
    int model_pub = 0;
    int reset_at  = -1;
    bit mon_en    = 1'b0;
    int exp_valid[int];     // cycle -> published count
    bit exp_short[int];     // cycle -> frame_short expected

    function automatic int absdiff(input int a, input int b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    logic [PW-1:0] pa [N];
    logic [PW-1:0] ca [N];
    logic [PW-1:0] ta [N];

    // One input cycle: driven on the falling edge, sampled on rising edge s.
    task automatic drive(input bit fs, input bit pv, input logic [PW-1:0] p,
                         input logic [PW-1:0] c, input logic [PW-1:0] t);
        int s;
        @(negedge clk);
        frame_start     = fs;
        pixel_valid     = pv;
        prev_pixel      = p;
        curr_pixel      = c;
        noise_threshold = t;
        s = cyc + 1;
        if (fs) begin
            if (in_frame) exp_short[s] = 1'b1;
            in_frame = 1'b1;
            pix_cnt  = 0;
            hit_cnt  = 0;
        end
        if (pv && in_frame) begin
            pix_cnt++;
            if (absdiff(int'(p), int'(c)) > int'(t)) hit_cnt++;
            if (pix_cnt == N) begin
                exp_valid[s + 2] = hit_cnt;
                in_frame = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'($urandom_range(1)), PW'($urandom), PW'($urandom), PW'($urandom));
        end
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset       = 1'b1;
        frame_start = 1'b0;
        pixel_valid = 1'b0;
        reset_at    = cyc + 1;
        exp_valid.delete();
        exp_short.delete();
        in_frame    = 1'b0;
        mon_en      = 1'b1;
        repeat (cycles - 1) @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Sends the first `count` pixels of the arrays, optionally with gaps.
    task automatic send_frame(input int count, input int gap_pct);
        bit fs;
        fs = 1'b1;
        for (int i = 0; i < count; i++) begin
            while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
                drive(fs, 1'b0, PW'($urandom), PW'($urandom), PW'($urandom));
                fs = 1'b0;
            end
            drive(fs, 1'b1, pa[i], ca[i], ta[i]);
            fs = 1'b0;
        end
    endtask

    // Unchanged pixels everywhere except `hits` pixels that differ by 15.
    // thr < 0 picks a random per-pixel threshold in 0..14.
    task automatic make_frame(input int hits, input int thr);
        bit mark [N];
        int placed;
        int k;
        placed = 0;
        for (int i = 0; i < N; i++) begin
            pa[i]   = PW'($urandom);
            ca[i]   = pa[i];
            ta[i]   = (thr < 0) ? PW'($urandom_range(14)) : PW'(thr);
            mark[i] = 1'b0;
        end
        while (placed < hits) begin
            k = int'($urandom_range(N - 1));
            if (!mark[k]) begin
                mark[k] = 1'b1;
                placed++;
                if ($urandom_range(1) == 1) begin
                    pa[k] = 4'd0;  ca[k] = 4'd15;
                end else begin
                    pa[k] = 4'd15; ca[k] = 4'd0;
                end
            end
        end
    endtask

    // D3_HITS pixels differ by exactly 3, the rest not at all.
    task automatic make_d3_frame(input int thr);
        int k;
        for (int i = 0; i < N; i++) begin
            pa[i] = PW'($urandom);
            ca[i] = pa[i];
            ta[i] = PW'(thr);
        end
        // Every 12th pixel, starting at a random offset, gives distinct slots.
        k = int'($urandom_range(11));
        for (int j = 0; j < D3_HITS; j++) begin
            pa[k + 12 * j] = PW'($urandom_range(3, 12));
            ca[k + 12 * j] = ($urandom_range(1) == 1) ? pa[k + 12 * j] + 4'd3
                                                      : pa[k + 12 * j] - 4'd3;
        end
    endtask

    task automatic set_thr(input int thr);
        for (int i = 0; i < N; i++) ta[i] = PW'(thr);
    endtask

    task automatic make_full15(input int thr);
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(1) == 1) begin
                pa[i] = 4'd0;  ca[i] = 4'd15;
            end else begin
                pa[i] = 4'd15; ca[i] = 4'd0;
            end
            ta[i] = PW'(thr);
        end
    endtask

    // ------------------------------------------------------------------
    // Cycle monitor
    // ------------------------------------------------------------------
    always begin
        bit ev;
        bit es;
        @(posedge clk);
        #2;
        if (mon_en) begin
            if (cyc == reset_at) model_pub = 0;
            ev = exp_valid.exists(cyc);
            es = exp_short.exists(cyc);
            if (ev) model_pub = exp_valid[cyc];
            check_val("cnt_valid", 32'(cnt_valid), 32'(ev));
            check_val("diff_pixel_cnt", 32'(diff_pixel_cnt), 32'(model_pub));
            check_val("frame_short", 32'(frame_short), 32'(es));
            if (cnt_valid === 1'b1)
                $display("publish  cycle %0d count %0d", cyc, diff_pixel_cnt);
            if (frame_short === 1'b1)
                $display("short    cycle %0d", cyc);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        reset           = 1'b1;
        frame_start     = 1'b0;
        pixel_valid     = 1'b0;
        prev_pixel      = '0;
        curr_pixel      = '0;
        noise_threshold = '0;

        do_reset(3);
        idle(3);
        check_val("reset_cnt", 32'(diff_pixel_cnt), 32'd0);

        // Unchanged frame, threshold 0.
        make_frame(0, 0);
        send_frame(N, 0);
        idle(4);
        check_val("equal_thr0", 32'(diff_pixel_cnt), 32'd0);

        // |diff| = 3 on a few pixels: threshold 2 counts them, 3 does not.
        make_d3_frame(2);
        send_frame(N, 0);
        idle(4);
        check_val("d3_thr2", 32'(diff_pixel_cnt), 32'(D3_HITS));
        set_thr(3);
        send_frame(N, 0);
        idle(4);
        check_val("d3_thr3", 32'(diff_pixel_cnt), 32'd0);

        // Every pixel differs by 15: threshold 0 counts all, 15 counts none.
        make_full15(0);
        send_frame(N, 0);
        idle(4);
        check_val("all15_thr0", 32'(diff_pixel_cnt), 32'(N));
        set_thr(15);
        send_frame(N, 0);
        idle(4);
        check_val("all15_thr15", 32'(diff_pixel_cnt), 32'd0);
        set_thr(0);
        send_frame(N, 35);
        idle(4);
        check_val("all15_gaps", 32'(diff_pixel_cnt), 32'(N));

        // Early restart: previous total held, restarted frame publishes.
        make_frame(25, -1);
        send_frame(50, 0);
        idle(3);
        check_val("short_hold", 32'(diff_pixel_cnt), 32'(N));
        make_frame(20, -1);
        send_frame(N, 0);
        idle(4);
        check_val("after_short", 32'(diff_pixel_cnt), 32'd20);

        // Back-to-back frames, second frame_start lands in the flush cycle.
        make_frame(7, -1);
        send_frame(N, 0);
        make_frame(90, -1);
        send_frame(N, 0);
        idle(4);
        check_val("b2b_second", 32'(diff_pixel_cnt), 32'd90);

        // Reset mid-frame, then reset in the flush cycle of a full frame.
        make_frame(40, -1);
        send_frame(60, 0);
        do_reset(2);
        idle(3);
        check_val("rst_mid", 32'(diff_pixel_cnt), 32'd0);
        make_frame(33, -1);
        send_frame(N, 0);
        do_reset(1);
        idle(4);
        check_val("rst_flush", 32'(diff_pixel_cnt), 32'd0);

        // Random frames: random pixels/thresholds, gaps, random aborts.
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < N; i++) begin
                pa[i] = PW'($urandom);
                ca[i] = PW'($urandom);
                ta[i] = PW'($urandom);
            end
            if ($urandom_range(2) == 0) send_frame(int'($urandom_range(1, N - 1)), 20);
            send_frame(N, (f % 2) * 30);
            idle(int'($urandom_range(0, 3)));
        end
        idle(4);
        check_val("random_final", 32'(diff_pixel_cnt), 32'(model_pub));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete at time %0t", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
